// File: rtl/seg_scan_decoder_pkg.sv
// Shared constants, glyph table and small helpers for the 7-segment scan
// readback path.
package seg_scan_decoder_pkg;

  localparam int NDIG = 8;

  // Bit positions within the segment bus {dp,g,f,e,d,c,b,a}
  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  // Active-high segment patterns {g,f,e,d,c,b,a} for hex digits 0..F
  localparam logic [6:0] GLYPH [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  typedef enum logic [1:0] {
    IDLE,
    SETTLING,
    HOLD
  } scan_state_e;

  typedef enum logic [1:0] {
    SEL_IDLE,
    SEL_VALID,
    SEL_BAD
  } sel_class_e;

  // All-high means nothing selected; exactly one low bit is a legal select.
  function automatic sel_class_e classify_sel(input logic [7:0] sel);
    if (sel == 8'hFF) return SEL_IDLE;
    if ($countones(~sel) == 1) return SEL_VALID;
    return SEL_BAD;
  endfunction

  // Index of the low bit of an active-low one-hot select.
  function automatic logic [2:0] sel_index(input logic [7:0] sel);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < NDIG; i++) begin
      if (!sel[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/seg_scan_decoder_glyph.sv
// Combinational glyph-to-nibble decoder: active-high segments in,
// {nibble, blank, bad} out.
module seg7_glyph_decode
  import seg_scan_decoder_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] nibble,
  output logic       blank,
  output logic       bad
);

  // Table search; unmatched non-blank patterns are flagged bad with nibble 0
  always_comb begin
    // NOTE: every output gets a default before the search so no path leaves a
    // value unassigned and no latch is inferred.
    nibble = 4'h0;
    blank  = (seg == 7'h00);
    bad    = (seg != 7'h00);
    for (int i = 0; i < 16; i++) begin
      if (seg == GLYPH[i]) begin
        nibble = 4'(i);
        bad    = 1'b0;
      end
    end
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// Scan-interface receiver: synchronizes digit-select and segment pins,
// waits for a stable select, decodes each digit and publishes complete
// 8-digit frames with a one-cycle valid strobe.
module seg_scan_decoder
  import seg_scan_decoder_pkg::*;
#(
  parameter int SETTLE      = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  led_id,
  input  logic [7:0]  out_led,
  output logic [31:0] digits,
  output logic [7:0]  blank,
  output logic [7:0]  dp,
  output logic        frame_valid,
  output logic        seg_err,
  output logic        scan_err
);

  // ---------------------------------------------------------------------
  // Input synchronizers (reset to all-high = nothing selected, segments off)
  // ---------------------------------------------------------------------
  logic [7:0] id_sync_q  [SYNC_STAGES];
  logic [7:0] seg_sync_q [SYNC_STAGES];

  // Shift both pin groups through SYNC_STAGES flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        id_sync_q[i]  <= 8'hFF;
        seg_sync_q[i] <= 8'hFF;
      end
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge value of its neighbour, giving a true shift.
      id_sync_q[0]  <= led_id;
      seg_sync_q[0] <= out_led;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        id_sync_q[i]  <= id_sync_q[i-1];
        seg_sync_q[i] <= seg_sync_q[i-1];
      end
    end
  end

  logic [7:0] sid;
  logic [7:0] sseg;
  sel_class_e sel;

  assign sid  = id_sync_q[SYNC_STAGES-1];
  assign sseg = seg_sync_q[SYNC_STAGES-1];
  assign sel  = classify_sel(sid);

  // ---------------------------------------------------------------------
  // Glyph decode of the currently presented segments
  // ---------------------------------------------------------------------
  logic [6:0] seg_on;
  logic       dp_on;
  logic [3:0] dec_nibble;
  logic       dec_blank;
  logic       dec_bad;

  assign seg_on = ~sseg[SEG_G:SEG_A];
  assign dp_on  = ~sseg[SEG_DP];

  seg7_glyph_decode u_glyph (
    .seg    (seg_on),
    .nibble (dec_nibble),
    .blank  (dec_blank),
    .bad    (dec_bad)
  );

  // ---------------------------------------------------------------------
  // Select-settling FSM
  // ---------------------------------------------------------------------
  scan_state_e state_q, state_d;
  logic [7:0]  cur_id_q, cur_id_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        capture;

  // Next-state: track the selected digit and count stable cycles
  always_comb begin
    state_d  = state_q;
    cur_id_d = cur_id_q;
    cnt_d    = cnt_q;
    capture  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (sel == SEL_VALID) begin
          cur_id_d = sid;
          cnt_d    = 4'd1;
          state_d  = SETTLING;
        end
      end
      SETTLING: begin
        if (sel != SEL_VALID) begin
          state_d = IDLE;
        end else if (sid != cur_id_q) begin
          cur_id_d = sid;
          cnt_d    = 4'd1;
        end else if (cnt_q == 4'(SETTLE)) begin
          capture = 1'b1;
          state_d = HOLD;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      HOLD: begin
        if (sel != SEL_VALID) begin
          state_d = IDLE;
        end else if (sid != cur_id_q) begin
          cur_id_d = sid;
          cnt_d    = 4'd1;
          state_d  = SETTLING;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cur_id_q <= 8'hFF;
      cnt_q    <= 4'd0;
    end else begin
      state_q  <= state_d;
      cur_id_q <= cur_id_d;
      cnt_q    <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------
  // Frame assembly: shadow registers, seen mask, frame error flag
  // ---------------------------------------------------------------------
  logic [31:0] shadow_digits_q, shadow_digits_d;
  logic [7:0]  shadow_blank_q, shadow_blank_d;
  logic [7:0]  shadow_dp_q, shadow_dp_d;
  logic [7:0]  seen_q, seen_d;
  logic        frm_err_q, frm_err_d;
  logic [2:0]  cap_idx;
  logic        complete;

  assign cap_idx  = sel_index(cur_id_q);
  assign complete = (seen_q == 8'hFF);

  // Store a captured digit, or close the frame once every digit was seen
  always_comb begin
    shadow_digits_d = shadow_digits_q;
    shadow_blank_d  = shadow_blank_q;
    shadow_dp_d     = shadow_dp_q;
    seen_d          = seen_q;
    frm_err_d       = frm_err_q;
    if (complete) begin
      seen_d    = 8'h00;
      frm_err_d = 1'b0;
    end else if (capture) begin
      shadow_digits_d[{cap_idx, 2'b00} +: 4] = dec_nibble;
      shadow_blank_d[cap_idx]                = dec_blank;
      shadow_dp_d[cap_idx]                   = dp_on;
      seen_d[cap_idx]                        = 1'b1;
      if (dec_bad) frm_err_d = 1'b1;
    end
  end

  // Frame assembly registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the shadow store is only 48 bits of flops, so it is reset along
      // with the rest; larger RAM-style storage would normally be left unreset.
      shadow_digits_q <= '0;
      shadow_blank_q  <= '0;
      shadow_dp_q     <= '0;
      seen_q          <= '0;
      frm_err_q       <= 1'b0;
    end else begin
      shadow_digits_q <= shadow_digits_d;
      shadow_blank_q  <= shadow_blank_d;
      shadow_dp_q     <= shadow_dp_d;
      seen_q          <= seen_d;
      frm_err_q       <= frm_err_d;
    end
  end

  // ---------------------------------------------------------------------
  // Registered outputs
  // ---------------------------------------------------------------------
  logic [31:0] digits_q, digits_d;
  logic [7:0]  blank_q, blank_d;
  logic [7:0]  dp_q, dp_d;
  logic        frame_valid_q, frame_valid_d;
  logic        seg_err_q, seg_err_d;
  logic        scan_err_q, scan_err_d;

  // Publish the shadow frame on completion; flag malformed selects
  always_comb begin
    digits_d      = digits_q;
    blank_d       = blank_q;
    dp_d          = dp_q;
    seg_err_d     = seg_err_q;
    frame_valid_d = complete;
    scan_err_d    = (sel == SEL_BAD);
    if (complete) begin
      digits_d  = shadow_digits_q;
      blank_d   = shadow_blank_q;
      dp_d      = shadow_dp_q;
      seg_err_d = frm_err_q;
    end
  end

  // Output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digits_q      <= '0;
      blank_q       <= '0;
      dp_q          <= '0;
      frame_valid_q <= 1'b0;
      seg_err_q     <= 1'b0;
      scan_err_q    <= 1'b0;
    end else begin
      digits_q      <= digits_d;
      blank_q       <= blank_d;
      dp_q          <= dp_d;
      frame_valid_q <= frame_valid_d;
      seg_err_q     <= seg_err_d;
      scan_err_q    <= scan_err_d;
    end
  end

  assign digits      = digits_q;
  assign blank       = blank_q;
  assign dp          = dp_q;
  assign frame_valid = frame_valid_q;
  assign seg_err     = seg_err_q;
  assign scan_err    = scan_err_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Scoreboard bench for seg_scan_decoder: the driver models which digit holds
// get captured and pushes expected frames; a monitor pops on frame_valid.
module tb_seg_scan_decoder;

  localparam int SETTLE = 2;
  localparam int SYNC   = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  led_id;
  logic [7:0]  out_led;
  logic [31:0] digits;
  logic [7:0]  blank;
  logic [7:0]  dp;
  logic        frame_valid;
  logic        seg_err;
  logic        scan_err;

  always #5 clk = ~clk;

  seg_scan_decoder #(.SETTLE(SETTLE), .SYNC_STAGES(SYNC)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .led_id      (led_id),
    .out_led     (out_led),
    .digits      (digits),
    .blank       (blank),
    .dp          (dp),
    .frame_valid (frame_valid),
    .seg_err     (seg_err),
    .scan_err    (scan_err)
  );

  typedef struct {
    logic [31:0] digits;
    logic [7:0]  blank;
    logic [7:0]  dp;
    logic        seg_err;
  } frame_t;

  frame_t exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int bad_cycles_exp = 0;
  int scan_err_seen  = 0;

  // Reference model state: what the current partial frame holds
  logic [3:0] m_nib   [8];
  bit         m_blank [8];
  bit         m_dp    [8];
  bit         m_seen  [8];
  bit         m_err;
  int         last_valid = -1;

  // Hex glyphs written as lit-segment letter sets
  string hex_glyph [16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg",
                            "acdefg", "abc", "abcdefg", "abcdfg", "abcefg",
                            "cdefg", "adef", "bcdeg", "adefg", "aefg"};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [6:0] segs_of(input string s);
    logic [6:0] r;
    r = '0;
    for (int i = 0; i < s.len(); i++) r[int'(s[i]) - 97] = 1'b1;
    return r;
  endfunction

  function automatic void decode_ref(input logic [6:0] segs, output logic [3:0] nib,
                                     output bit bl, output bit er);
    nib = 4'h0;
    bl  = (segs == 7'h00);
    er  = !bl;
    for (int i = 0; i < 16; i++) begin
      if (segs_of(hex_glyph[i]) == segs) begin
        nib = 4'(i);
        er  = 1'b0;
      end
    end
  endfunction

  function automatic void model_clear();
    for (int k = 0; k < 8; k++) m_seen[k] = 1'b0;
    m_err = 1'b0;
  endfunction

  // Idle (nothing selected) for n cycles
  task automatic gap(input int n);
    led_id  = 8'hFF;
    out_led = 8'hFF;
    repeat (n) @(posedge clk);
    #1;
    last_valid = -1;
  endtask

  // Illegal select pattern for n cycles
  task automatic bad_sel(input logic [7:0] sel, input int n);
    led_id  = sel;
    out_led = 8'($urandom);
    bad_cycles_exp += n;
    repeat (n) @(posedge clk);
    #1;
    last_valid = -1;
  endtask

  // Present digit d with the given lit segments for n cycles
  task automatic hold_digit(input int d, input logic [6:0] segs, input bit dpl, input int n);
    logic [3:0] nib;
    bit bl, er, all;
    frame_t f;
    if (last_valid == d) gap(1);
    led_id  = ~(8'h01 << d);
    out_led = {~dpl, ~segs};
    repeat (n) @(posedge clk);
    #1;
    last_valid = d;
    if (n >= SETTLE + 1) begin
      decode_ref(segs, nib, bl, er);
      m_nib[d] = nib; m_blank[d] = bl; m_dp[d] = dpl; m_seen[d] = 1'b1;
      if (er) m_err = 1'b1;
      all = 1'b1;
      for (int k = 0; k < 8; k++) if (!m_seen[k]) all = 1'b0;
      if (all) begin
        for (int k = 0; k < 8; k++) begin
          f.digits[4*k +: 4] = m_nib[k];
          f.blank[k]         = m_blank[k];
          f.dp[k]            = m_dp[k];
        end
        f.seg_err = m_err;
        exp_q.push_back(f);
        model_clear();
      end
    end
  endtask

  task automatic flush_and_check(input string name);
    gap(SYNC + SETTLE + 6);
    check({name, "_scan_err_count"}, scan_err_seen, bad_cycles_exp);
    check({name, "_frames_pending"}, exp_q.size(), 0);
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_digits"}, digits, 0);
    check({name, "_blank"}, blank, 0);
    check({name, "_dp"}, dp, 0);
    check({name, "_frame_valid"}, frame_valid, 0);
    check({name, "_seg_err"}, seg_err, 0);
    check({name, "_scan_err"}, scan_err, 0);
  endtask

  function automatic logic [6:0] rand_glyph();
    int r;
    logic [6:0] s;
    logic [3:0] nib;
    bit bl, er;
    r = $urandom_range(0, 9);
    if (r == 0) return 7'h00;
    if (r == 1) begin
      do begin
        s = 7'($urandom_range(1, 127));
        decode_ref(s, nib, bl, er);
      end while (!er);
      return s;
    end
    return segs_of(hex_glyph[$urandom_range(0, 15)]);
  endfunction

  // Monitor: compare each published frame against the scoreboard
  always @(negedge clk) begin
    if (rst_n) begin
      if (scan_err) scan_err_seen++;
      if (frame_valid) begin
        check("frame_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          frame_t f;
          f = exp_q.pop_front();
          check("frame_digits", digits, f.digits);
          check("frame_blank", blank, f.blank);
          check("frame_dp", dp, f.dp);
          check("frame_seg_err", seg_err, f.seg_err);
        end
      end
    end
  end

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n   = 1'b0;
    led_id  = 8'hFF;
    out_led = 8'hFF;
    model_clear();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;
    gap(2);

    // Glyphs 0..7 on digits 0..7
    for (int d = 0; d < 8; d++) hold_digit(d, segs_of(hex_glyph[d]), 1'b0, 4);
    flush_and_check("basic");
    check("basic_digits", digits, 32'h76543210);

    // All F, digit 3 dp lit, digit 5 blank
    for (int d = 0; d < 8; d++)
      hold_digit(d, (d == 5) ? 7'h00 : segs_of("aefg"), d == 3, 4);
    flush_and_check("blank_dp");
    check("blank_dp_digits", digits, 32'hFF0FFFFF);
    check("blank_dp_blank", blank, 8'h20);
    check("blank_dp_dp", dp, 8'h08);

    // Digit 2 shows a+d only, then a clean frame
    for (int d = 0; d < 8; d++)
      hold_digit(d, (d == 2) ? segs_of("ad") : segs_of(hex_glyph[8]), 1'b0, 4);
    flush_and_check("bad_glyph");
    check("bad_glyph_seg_err", seg_err, 1);
    check("bad_glyph_nibble2", digits[11:8], 0);
    for (int d = 0; d < 8; d++) hold_digit(d, segs_of(hex_glyph[d + 8]), 1'b0, 4);
    flush_and_check("clean_after_bad");
    check("clean_after_bad_seg_err", seg_err, 0);

    // Two digits selected at once for 3 cycles mid-scan
    for (int d = 0; d < 4; d++) hold_digit(d, segs_of(hex_glyph[d]), 1'b0, 4);
    bad_sel(8'b11110011, 3);
    for (int d = 4; d < 8; d++) hold_digit(d, segs_of(hex_glyph[d]), 1'b0, 4);
    flush_and_check("bad_select");

    // Digit 4 glitches for one cycle; frame only completes once it is held
    for (int d = 0; d < 4; d++) hold_digit(d, segs_of(hex_glyph[15 - d]), 1'b0, 4);
    hold_digit(4, segs_of(hex_glyph[4]), 1'b0, 1);
    for (int d = 5; d < 8; d++) hold_digit(d, segs_of(hex_glyph[15 - d]), 1'b0, 4);
    flush_and_check("glitch_no_frame");
    hold_digit(4, segs_of(hex_glyph[10]), 1'b1, 4);
    flush_and_check("glitch_then_held");

    // Reset mid-frame discards the partial frame
    for (int d = 0; d < 5; d++) hold_digit(d, segs_of(hex_glyph[d]), 1'b0, 4);
    rst_n   = 1'b0;
    led_id  = 8'hFF;
    out_led = 8'hFF;
    #1;
    check_all_zero("mid_reset");
    model_clear();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    last_valid = -1;
    for (int d = 5; d < 8; d++) hold_digit(d, segs_of(hex_glyph[d]), 1'b0, 4);
    flush_and_check("after_reset_partial");
    for (int d = 0; d < 8; d++) hold_digit(d, segs_of(hex_glyph[7 - d]), 1'b0, 4);
    flush_and_check("after_reset_full");

    // Randomized scans with glitches, illegal selects, gaps and re-captures
    for (int fr = 0; fr < 25; fr++) begin
      for (int d = 0; d < 8; d++) begin
        int r;
        r = $urandom_range(0, 99);
        if (r < 15) begin
          hold_digit($urandom_range(0, 7), rand_glyph(), 1'($urandom), $urandom_range(1, SETTLE));
        end else if (r < 25) begin
          int a, b;
          a = $urandom_range(0, 7);
          b = (a + $urandom_range(1, 7)) % 8;
          bad_sel(~((8'h01 << a) | (8'h01 << b)), $urandom_range(1, 3));
        end else if (r < 35) begin
          gap($urandom_range(1, 3));
        end else if (r < 45) begin
          hold_digit($urandom_range(0, 7), rand_glyph(), 1'($urandom), SETTLE + 2);
        end
        hold_digit(d, rand_glyph(), 1'($urandom), $urandom_range(SETTLE + 1, SETTLE + 4));
      end
    end
    flush_and_check("random");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/seg_scan_decoder.md
Name: seg_scan_decoder

Overview:
Monitor/receiver for the multiplexed 7-segment scan interface driven by the display printer. It samples the digit-select and segment lines and decodes each digit's glyph back to a 4-bit hex nibble. It reassembles a full 8-digit frame and presents it as a 32-bit value with a one-cycle valid strobe. It sits beside the CPU print path as a self-check/readback block, in the opposite direction to the printer (pins to binary).

Parameters:
SETTLE, 2, consecutive synchronized cycles a digit select must be stable before its segments are captured (range 1-15)
SYNC_STAGES, 2, input synchronizer depth; the printer launches on ~clk

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
led_id  input  8  digit select, active-low one-hot; bit i low selects digit i
out_led  input  8  segments, active-low, bit order {dp,g,f,e,d,c,b,a}
digits  output  32  decoded frame; digit i in bits [4i+3:4i]
blank  output  8  bit i = 1 when digit i had all segments a-g off
dp  output  8  bit i = decimal point state of digit i (1 = lit)
frame_valid  output  1  one-cycle pulse when digits/blank/dp update
seg_err  output  1  sticky per frame: some digit in the frame had an undecodable glyph
scan_err  output  1  one-cycle pulse when a synchronized led_id is neither one-hot-low nor all-high

Behaviour:
- Reset: all outputs 0. Shadow registers, seen mask, settle counter and synchronizers are cleared. Synchronizers reset to 8'hFF, which means no digit selected.
- Both inputs pass through SYNC_STAGES flops; all logic below uses the synchronized values (sid, sseg).
- Select classification: IDLE_SEL when sid == 8'hFF; VALID when exactly one bit is low; otherwise BAD.
- BAD asserts scan_err for that cycle and is treated as IDLE_SEL.
- FSM states: IDLE, SETTLING, HOLD.
  - IDLE: a VALID sid loads it into cur_id, sets cnt = 1 and moves to SETTLING.
  - SETTLING: sid == cur_id with cnt == SETTLE triggers a capture and moves to HOLD; with cnt < SETTLE it increments cnt. If sid changes to another VALID value, reload cur_id and cnt = 1 and stay in SETTLING. If sid changes to IDLE_SEL or BAD, go to IDLE.
  - HOLD: no further capture until sid changes. A new VALID value goes to SETTLING with cnt = 1; IDLE_SEL or BAD goes to IDLE.
- Capture of digit k:
  - Decode ~sseg[6:0] against the standard hex glyphs: 0=abcdef, 1=bc, 2=abdeg, 3=abcdg, 4=bcfg, 5=acdfg, 6=acdefg, 7=abc, 8=abcdefg, 9=abcdfg, A=abcefg, b=cdefg, C=adef, d=bcdeg, E=adefg, F=aefg.
  - All segments off: nibble 0, blank bit = 1.
  - Any other pattern: nibble 0, blank bit = 0, set the frame error flag.
  - dp bit = ~sseg[7]. Set seen[k].
  - Re-capturing a digit before the frame completes overwrites its shadow entry. This is not an error.
- Frame completion: in the cycle after the capture that makes seen == 8'hFF:
  - digits, blank and dp load from the shadow registers; seg_err loads the frame error flag.
  - frame_valid = 1 for one cycle.
  - seen and the frame error flag clear. Shadow registers hold their contents.
- Outputs hold between frames. Latency from a stable select at the pins to capture is SYNC_STAGES + SETTLE cycles; frame_valid follows the last capture by 1 cycle.
- A capture and a frame completion in the same cycle cannot occur, because every capture is separated by at least SETTLE cycles.
- Reset asserted mid-frame discards the partial frame; the first frame after reset needs all 8 digits again.

Decomposition:
- Shared package holds:
  - NDIG = 8
  - segment bit-index constants SEG_A..SEG_G, SEG_DP
  - the 16-entry glyph constant table
  - the FSM state enum {IDLE, SETTLING, HOLD}
- One sub-module: seg7_glyph_decode. Combinational; takes 7 active-high segments and returns {nibble[3:0], blank, bad}.
- The FSM, seen mask and shadow registers stay in the top module.

Test Plan:
- Scan digits 0..7 with glyphs 0,1,2,3,4,5,6,7, each held 4 cycles, SETTLE=2 -> one frame_valid, digits = 32'h76543210, blank = 0, dp = 0, seg_err = 0.
- Scan 8 digits all showing F, digit 3 with dp lit, digit 5 all segments off -> digits = 32'hFF0FFFFF, blank = 8'h20, dp = 8'h08.
- Digit 2 shows segments a+d only (invalid), others valid -> frame_valid with seg_err = 1 and nibble 2 = 0. The next clean frame -> seg_err = 0.
- led_id = 8'b11110011 for 3 cycles mid-scan -> scan_err pulses 3 times (offset by the sync delay), no capture, and the frame still completes once all digits are seen.
- Digit 4 selected for only 1 stable cycle (glitch) with SETTLE=2 -> not captured, and no frame_valid until digit 4 is properly held.
- rst_n pulsed low after 5 digits captured -> outputs 0 immediately. 3 more digits after reset -> no frame_valid. A full 8-digit scan -> frame_valid.
